uart_tx_ctrl: RTL

//   Transmit-side sequencer for the APB UART. Accepts one byte per valid/ready handshake.

---
 rtl/uart_tx_ctrl.sv | 107 ++++++++++
 1 files changed

// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl: UART transmit sequencer; frames one handshaken word onto txd, one bit per baudtick.
module uart_tx_ctrl #(
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 nrst,
  input  logic                 baudtick,
  output logic                 baud_en,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 txd,
  output logic                 tx_busy,
  output logic                 frame_done
);
  localparam int BW = $clog2(DATA_BITS);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  state_t               state, state_n;
  logic [DATA_BITS-1:0] shreg, shreg_n;
  logic [BW-1:0]        bitcnt, bitcnt_n;
  logic                 par, par_n, stopcnt, stopcnt_n;
  logic                 txd_n, tx_ready_n, tx_busy_n, baud_en_n, frame_done_n;
  always_comb begin
    state_n      = state;
    shreg_n      = shreg;
    bitcnt_n     = bitcnt;
    par_n        = par;
    stopcnt_n    = stopcnt;
    txd_n        = txd;
    tx_ready_n   = tx_ready;
    tx_busy_n    = tx_busy;
    baud_en_n    = baud_en;
    frame_done_n = 1'b0;
    case (state)
      IDLE: if (tx_valid && tx_ready) begin
        state_n    = START;
        shreg_n    = tx_data;
        par_n      = (^tx_data) ^ 1'(PARITY_ODD);
        txd_n      = 1'b0;
        baud_en_n  = 1'b1;
        tx_ready_n = 1'b0;
        tx_busy_n  = 1'b1;
      end
      START: if (baudtick) begin
        state_n  = DATA;
        txd_n    = shreg[0];
        bitcnt_n = '0;
      end
      DATA: if (baudtick) begin
        if (bitcnt == BW'(DATA_BITS - 1)) begin
          state_n   = (PARITY_EN != 0) ? PARITY : STOP;
          txd_n     = (PARITY_EN != 0) ? par : 1'b1;
          stopcnt_n = 1'b0;
        end else begin
          shreg_n  = shreg >> 1;
          txd_n    = shreg[1];
          bitcnt_n = bitcnt + 1'b1;
        end
      end
      PARITY: if (baudtick) begin
        state_n   = STOP;
        txd_n     = 1'b1;
        stopcnt_n = 1'b0;
      end
      STOP: if (baudtick) begin
        if (stopcnt == 1'(STOP_BITS - 1)) begin
          state_n      = IDLE;
          frame_done_n = 1'b1;
          baud_en_n    = 1'b0;
          tx_ready_n   = 1'b1;
          tx_busy_n    = 1'b0;
        end else begin
          stopcnt_n = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state      <= IDLE;
      shreg      <= '0;
      bitcnt     <= '0;
      par        <= 1'b0;
      stopcnt    <= 1'b0;
      txd        <= 1'b1;
      tx_ready   <= 1'b1;
      tx_busy    <= 1'b0;
      baud_en    <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_n;
      shreg      <= shreg_n;
      bitcnt     <= bitcnt_n;
      par        <= par_n;
      stopcnt    <= stopcnt_n;
      txd        <= txd_n;
      tx_ready   <= tx_ready_n;
      tx_busy    <= tx_busy_n;
      baud_en    <= baud_en_n;
      frame_done <= frame_done_n;
    end
  end
endmodule
